// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions.
//
// Contents:
//   CLK_FREQ_DEFAULT, BAUD_DEFAULT, OVERSAMPLE_DEFAULT - default timing parameters
//   FRAME_BITS / DATA_BITS  - 8N1 frame geometry (start + 8 data + stop)
//   MID_PHASE               - oversample phase treated as the bit centre
//   frame_t                 - raw frame shift register type
//   calc_div()              - clocks per oversample tick
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT   = 50_000_000;
  localparam int unsigned BAUD_DEFAULT       = 9600;
  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned BIT_CNT_W  = 4;
  localparam int unsigned PHASE_W    = 4;

  localparam logic [BIT_CNT_W-1:0] FRAME_BITS_CNT = BIT_CNT_W'(FRAME_BITS);
  localparam logic [PHASE_W-1:0]   MID_PHASE      = PHASE_W'(7);

  typedef logic [FRAME_BITS-1:0] frame_t;

  // Truncating divide. A zero result would stall the divider forever, so it is
  // clamped to one tick per clock.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    int unsigned div;
    div = clk_freq / (baud * oversample);
    if (div == 0) begin
      div = 1;
    end
    return div;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator.
//
// Emits a single-clock tick every DIV clocks while enable is high. The count is
// held at zero while disabled or cleared, so the first tick after enabling (or
// after a clear) arrives exactly DIV clocks later.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset
//   enable - run the divider
//   clear  - zero the divider; suppresses a tick in the same cycle
//   tick   - one-cycle pulse every DIV enabled clocks
module baud_tick_gen #(
  parameter int unsigned DIV = 325
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = enable & ~clear & (cnt_q == CntMax);
    cnt_d = cnt_q + 1'b1;
    if (clear || !enable || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_shift_sampler.sv
// UART receive datapath: synchroniser, oversampled mid-bit sampler, frame shift
// register and output capture register. Sequencing (when to enable, clear and
// load) belongs to an external receive controller.
//
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous active-low reset
//   rx          - asynchronous serial input, idle high
//   baud_enable - run the tick divider and allow sampling
//   clear       - zero bit counter, phase counter and divider (shift reg kept)
//   load        - capture data byte and frame check from the shift register
//   start       - rx after two synchroniser stages
//   bit_counter - samples taken in the current frame, saturates at 10
//   data        - last captured byte
//   data_valid  - one-cycle pulse following a load
//   frame_error - last capture had start != 0 or stop != 1
module rx_shift_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DEFAULT,
  parameter int unsigned BAUD       = BAUD_DEFAULT,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 baud_enable,
  input  logic                 clear,
  input  logic                 load,
  output logic                 start,
  output logic [BIT_CNT_W-1:0] bit_counter,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_error
);

  localparam int unsigned Div = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  frame_t               shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_error_q, frame_error_d;
  logic                 tick;
  logic                 sample;

  baud_tick_gen #(
    .DIV(Div)
  ) u_baud_tick_gen (
    .clk   (clk),
    .reset (reset),
    .enable(baud_enable),
    .clear (clear),
    .tick  (tick)
  );

  // Two-stage synchroniser; idles high so a reset never looks like a start bit.
  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
  end

  // Sample counters and shift register. Clear has priority over a coincident
  // tick so a controller restart never lets a stale mid-bit sample through.
  always_comb begin
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sample    = tick & ~clear & (phase_q == MID_PHASE) & (bit_cnt_q < FRAME_BITS_CNT);

    if (clear) begin
      phase_d   = '0;
      bit_cnt_d = '0;
    end else if (tick) begin
      phase_d = phase_q + 1'b1;
      if (sample) begin
        // LSB-first line: each new bit enters at the top and walks down.
        shift_d   = {sync2_q, shift_q[FRAME_BITS-1:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  // Output capture. Independent of clear so load+clear in one cycle does both.
  always_comb begin
    data_d        = data_q;
    frame_error_d = frame_error_q;
    data_valid_d  = load;
    if (load) begin
      data_d        = shift_q[DATA_BITS:1];
      frame_error_d = shift_q[0] | ~shift_q[FRAME_BITS-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      phase_q       <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '1;
      data_q        <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      phase_q       <= phase_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    start       = sync2_q;
    bit_counter = bit_cnt_q;
    data        = data_q;
    data_valid  = data_valid_q;
    frame_error = frame_error_q;
  end

endmodule

// File: tb/tb_rx_shift_sampler.sv
// Directed bench for rx_shift_sampler with a small receive-controller model.
// The clock is scaled so that DIV = 700000 / (9600 * 16) = 4 (truncated from
// 4.557), giving 16 * 4 = 64 clocks per bit at 9600 baud.
module tb_rx_shift_sampler;

  localparam int unsigned TbClkFreq    = 700_000;
  localparam int unsigned TbBaud       = 9600;
  localparam int unsigned TbOversample = 16;
  localparam int          BitClks      = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       baud_enable;
  logic       clear;
  logic       load;
  logic       start;
  logic [3:0] bit_counter;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_error;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rx_shift_sampler #(
    .CLK_FREQ  (TbClkFreq),
    .BAUD      (TbBaud),
    .OVERSAMPLE(TbOversample)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .baud_enable(baud_enable),
    .clear      (clear),
    .load       (load),
    .start      (start),
    .bit_counter(bit_counter),
    .data       (data),
    .data_valid (data_valid),
    .frame_error(frame_error)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  // Drives nbits of {stop, b, start=0}; bit ext_idx is stretched by ext_len clocks.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int nbits,
                             input int ext_idx, input int ext_len);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      repeat (BitClks + ((i == ext_idx) ? ext_len : 0)) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic ctrl_begin(output logic to);
    to = 1'b1;
    for (int i = 0; i < BitClks * 40; i++) begin
      @(negedge clk);
      if (start === 1'b0) begin
        to = 1'b0;
        break;
      end
    end
    if (!to) begin
      clear       = 1'b1;
      baud_enable = 1'b1;
      @(negedge clk);
      clear = 1'b0;
    end
  endtask

  task automatic wait_bc(input logic [3:0] target, input int limit, output logic to);
    to = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bit_counter === target) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic ctrl_finish(output logic to, output int dv_cnt, output logic dv_next,
                             output logic [3:0] bc_after);
    to     = 1'b1;
    dv_cnt = 0;
    for (int i = 0; i < BitClks * 12; i++) begin
      @(negedge clk);
      dv_cnt += int'(data_valid);
      if (bit_counter === 4'd10) begin
        to = 1'b0;
        break;
      end
    end
    load        = 1'b1;
    clear       = 1'b1;
    baud_enable = 1'b0;
    @(negedge clk);
    load     = 1'b0;
    clear    = 1'b0;
    dv_next  = data_valid;
    bc_after = bit_counter;
    dv_cnt  += int'(data_valid);
    repeat (2) begin
      @(negedge clk);
      dv_cnt += int'(data_valid);
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input logic stop_bit, output logic to,
                           output int dv_cnt, output logic dv_next, output logic [3:0] bc_after);
    logic       to_b, to_f, dvn;
    int         cnt;
    logic [3:0] bca;
    @(negedge clk);
    fork
      drive_frame(b, stop_bit, 10, -1, 0);
      begin
        ctrl_begin(to_b);
        ctrl_finish(to_f, cnt, dvn, bca);
      end
    join
    to       = to_b | to_f;
    dv_cnt   = cnt;
    dv_next  = dvn;
    bc_after = bca;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    rx          = 1'b1;
    baud_enable = 1'b0;
    clear       = 1'b0;
    load        = 1'b0;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (start !== 1'b1) begin
      miscompares++; $display("FAIL rst_start: got %b exp 1", start);
    end
    vectors++;
    if (bit_counter !== 4'd0) begin
      miscompares++; $display("FAIL rst_bc: got %0d exp 0", bit_counter);
    end
    vectors++;
    if (data !== 8'h00) begin
      miscompares++; $display("FAIL rst_data: got %h exp 00", data);
    end
    vectors++;
    if (data_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_dv: got %b exp 0", data_valid);
    end
    vectors++;
    if (frame_error !== 1'b0) begin
      miscompares++; $display("FAIL rst_fe: got %b exp 0", frame_error);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sync_latency();
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    vectors++;
    if (start !== 1'b1) begin
      miscompares++; $display("FAIL sync_1clk: got %b exp 1", start);
    end
    @(negedge clk);
    vectors++;
    if (start !== 1'b0) begin
      miscompares++; $display("FAIL sync_2clk: got %b exp 0", start);
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_frame_55();
    logic to, dvn;
    int dvc;
    logic [3:0] bca;
    run_frame(8'h55, 1'b1, to, dvc, dvn, bca);
    vectors++;
    if (to !== 1'b0) begin
      miscompares++; $display("FAIL f55_timeout: got %b exp 0", to);
    end
    vectors++;
    if (data !== 8'h55) begin
      miscompares++; $display("FAIL f55_data: got %h exp 55", data);
    end
    vectors++;
    if (frame_error !== 1'b0) begin
      miscompares++; $display("FAIL f55_fe: got %b exp 0", frame_error);
    end
    vectors++;
    if (dvc !== 1) begin
      miscompares++; $display("FAIL f55_dv_count: got %0d exp 1", dvc);
    end
    vectors++;
    if (dvn !== 1'b1) begin
      miscompares++; $display("FAIL f55_dv_after_load: got %b exp 1", dvn);
    end
  endtask

  task automatic test_back_to_back();
    logic       to_a, to_b, to_c, to_d, dvn_a, dvn_b;
    int         dv_a, dv_b;
    logic [3:0] bc_a, bc_b;
    logic [7:0] d_a;
    @(negedge clk);
    fork
      begin
        drive_frame(8'hA3, 1'b1, 10, -1, 0);
        drive_frame(8'h00, 1'b1, 10, -1, 0);
      end
      begin
        ctrl_begin(to_a);
        ctrl_finish(to_b, dv_a, dvn_a, bc_a);
        d_a = data;
        ctrl_begin(to_c);
        ctrl_finish(to_d, dv_b, dvn_b, bc_b);
      end
    join
    vectors++;
    if ((to_a | to_b | to_c | to_d) !== 1'b0) begin
      miscompares++; $display("FAIL b2b_timeout: got 1 exp 0");
    end
    vectors++;
    if (d_a !== 8'hA3) begin
      miscompares++; $display("FAIL b2b_data1: got %h exp a3", d_a);
    end
    vectors++;
    if (data !== 8'h00) begin
      miscompares++; $display("FAIL b2b_data2: got %h exp 00", data);
    end
    vectors++;
    if (bc_a !== 4'd0) begin
      miscompares++; $display("FAIL b2b_bc_between: got %0d exp 0", bc_a);
    end
    vectors++;
    if (dv_a !== 1 || dv_b !== 1) begin
      miscompares++; $display("FAIL b2b_dv_count: got %0d/%0d exp 1/1", dv_a, dv_b);
    end
    vectors++;
    if (frame_error !== 1'b0) begin
      miscompares++; $display("FAIL b2b_fe: got %b exp 0", frame_error);
    end
  endtask

  task automatic test_stop_error();
    logic to, dvn;
    int dvc;
    logic [3:0] bca;
    run_frame(8'hFF, 1'b0, to, dvc, dvn, bca);
    vectors++;
    if (to !== 1'b0) begin
      miscompares++; $display("FAIL stop_timeout: got %b exp 0", to);
    end
    vectors++;
    if (data !== 8'hFF) begin
      miscompares++; $display("FAIL stop_data: got %h exp ff", data);
    end
    vectors++;
    if (frame_error !== 1'b1) begin
      miscompares++; $display("FAIL stop_fe: got %b exp 1", frame_error);
    end
  endtask

  task automatic test_reset_midframe();
    logic       to_b, to_w, st, dv, fe, to, dvn;
    logic [3:0] bc, bca;
    logic [7:0] d;
    int         dvc;
    @(negedge clk);
    fork
      drive_frame(8'h00, 1'b1, 5, -1, 0);
      begin
        ctrl_begin(to_b);
        wait_bc(4'd4, BitClks * 8, to_w);
        #2;
        reset       = 1'b0;
        baud_enable = 1'b0;
        #1;
        st = start;
        bc = bit_counter;
        d  = data;
        dv = data_valid;
        fe = frame_error;
      end
    join
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if ((to_b | to_w) !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_timeout: got 1 exp 0");
    end
    vectors++;
    if (st !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_start: got %b exp 1", st);
    end
    vectors++;
    if (bc !== 4'd0) begin
      miscompares++; $display("FAIL rstmid_bc: got %0d exp 0", bc);
    end
    vectors++;
    if (d !== 8'h00) begin
      miscompares++; $display("FAIL rstmid_data: got %h exp 00", d);
    end
    vectors++;
    if (dv !== 1'b0 || fe !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_dv_fe: got %b/%b exp 0/0", dv, fe);
    end
    run_frame(8'h3C, 1'b1, to, dvc, dvn, bca);
    vectors++;
    if (to !== 1'b0) begin
      miscompares++; $display("FAIL post_rst_timeout: got %b exp 0", to);
    end
    vectors++;
    if (data !== 8'h3C) begin
      miscompares++; $display("FAIL post_rst_data: got %h exp 3c", data);
    end
    vectors++;
    if (frame_error !== 1'b0 || dvc !== 1) begin
      miscompares++; $display("FAIL post_rst_fe_dv: got %b/%0d exp 0/1", frame_error, dvc);
    end
  endtask

  task automatic test_enable_gap();
    logic       to_b, to_w, to_f, moved, dvn;
    logic [3:0] bc_gap, bca;
    int         dvc;
    moved = 1'b0;
    @(negedge clk);
    fork
      drive_frame(8'h5A, 1'b1, 10, 3, 1000);
      begin
        ctrl_begin(to_b);
        wait_bc(4'd4, BitClks * 8, to_w);
        baud_enable = 1'b0;
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          if (bit_counter !== 4'd4) moved = 1'b1;
        end
        bc_gap      = bit_counter;
        baud_enable = 1'b1;
        ctrl_finish(to_f, dvc, dvn, bca);
      end
    join
    vectors++;
    if ((to_b | to_w | to_f) !== 1'b0) begin
      miscompares++; $display("FAIL gap_timeout: got 1 exp 0");
    end
    vectors++;
    if (moved !== 1'b0) begin
      miscompares++; $display("FAIL gap_bc_moved: got %b exp 0", moved);
    end
    vectors++;
    if (bc_gap !== 4'd4) begin
      miscompares++; $display("FAIL gap_bc_end: got %0d exp 4", bc_gap);
    end
    vectors++;
    if (data !== 8'h5A) begin
      miscompares++; $display("FAIL gap_data: got %h exp 5a", data);
    end
    vectors++;
    if (frame_error !== 1'b0) begin
      miscompares++; $display("FAIL gap_fe: got %b exp 0", frame_error);
    end
  endtask

  // After a clear, the 8th tick (phase 7) lands on the 32nd clock following the
  // negedge where clear is released. rx is held low so any sample would alter
  // the shift register (and the next capture) visibly.
  task automatic test_clear_tick();
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    clear       = 1'b1;
    baud_enable = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (31) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear       = 1'b0;
    baud_enable = 1'b0;
    vectors++;
    if (bit_counter !== 4'd0) begin
      miscompares++; $display("FAIL clrtick_bc: got %0d exp 0", bit_counter);
    end
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    vectors++;
    if (data !== 8'h5A) begin
      miscompares++; $display("FAIL clrtick_data: got %h exp 5a", data);
    end
    vectors++;
    if (frame_error !== 1'b0) begin
      miscompares++; $display("FAIL clrtick_fe: got %b exp 0", frame_error);
    end
    vectors++;
    if (data_valid !== 1'b1) begin
      miscompares++; $display("FAIL clrtick_dv: got %b exp 1", data_valid);
    end
    // Same sequence without the colliding clear: the sample must land there.
    clear       = 1'b1;
    baud_enable = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (31) @(negedge clk);
    vectors++;
    if (bit_counter !== 4'd0) begin
      miscompares++; $display("FAIL tick_pre_bc: got %0d exp 0", bit_counter);
    end
    @(negedge clk);
    vectors++;
    if (bit_counter !== 4'd1) begin
      miscompares++; $display("FAIL tick_phase7_bc: got %0d exp 1", bit_counter);
    end
    baud_enable = 1'b0;
    clear       = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    rx    = 1'b1;
    vectors++;
    if (data !== 8'h5A) begin
      miscompares++; $display("FAIL hold_data: got %h exp 5a", data);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sync_latency();
    test_frame_55();
    test_back_to_back();
    test_stop_error();
    test_reset_midframe();
    test_enable_gap();
    test_clear_tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_shift_sampler.md
RX_SHIFT_SAMPLER -- requirements
Module: rx_shift_sampler

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, ticks per bit period.
REQ-004 SHALL have port clk  input  1  system clock; one clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port baud_enable  input  1  from receive controller; enables tick and sampling.
REQ-008 SHALL have port clear  input  1  from receive controller; zeroes bit/tick counters.
REQ-009 SHALL have port load  input  1  from receive controller; captures frame to output register.
REQ-010 SHALL have port start  output  1  synchronised rx, fed to the controller's start input.
REQ-011 SHALL have port bit_counter  output  4  number of bits sampled in the current frame, 0..10.
REQ-012 SHALL have port data  output  8  last captured data byte.
REQ-013 SHALL have port data_valid  output  1  one-cycle pulse after capture.
REQ-014 SHALL have port frame_error  output  1  start/stop bit check result of last capture.

Function
REQ-015 SHALL synchronise rx through two flip-flops; start equals second stage; latency 2 clk.
REQ-016 SHALL compute DIV = CLK_FREQ/(BAUD*OVERSAMPLE), truncated (50 MHz/9600/16 -> 325).
REQ-017 SHALL pulse an internal tick for one clk every DIV clocks while baud_enable=1; divider held at 0 while baud_enable=0.
REQ-018 SHALL keep a 4-bit sample phase counter incremented on each tick, wrapping 15->0.
REQ-019 SHALL sample start on the tick where phase==7 (mid-bit) and bit_counter<10.
REQ-020 SHALL shift each sample into a 10-bit shift register, right shift, new bit at bit 9 (LSB-first frame).
REQ-021 SHALL increment bit_counter on each sample and saturate at 10; no sampling at 10.
REQ-022 SHALL, after 10 samples, hold start bit in shift[0], data in shift[8:1], stop bit in shift[9].
REQ-023 SHALL, on load=1, register data<=shift[8:1], frame_error<=(shift[0]!=0)|(shift[9]!=1), data_valid=1 next cycle only.
REQ-024 SHALL, on clear=1, zero bit_counter, phase counter and divider next cycle; shift register untouched; clear beats tick in same cycle.
REQ-025 SHALL, on simultaneous load and clear, perform both actions.
REQ-026 SHALL hold data and frame_error between loads.
REQ-027 SHALL tolerate baud_enable dropping mid-frame: counters freeze, no sample taken.

Reset
REQ-028 SHALL on reset=0 set sync stages and start to 1, bit_counter/phase/divider to 0, shift to 10'h3FF, data to 8'h00, data_valid and frame_error to 0.
REQ-029 SHALL apply reset asynchronously at any point, aborting a frame in progress; first frame after release behaves as from idle.

Structure
REQ-030 SHALL take CLK_FREQ, BAUD, OVERSAMPLE defaults and FRAME_BITS=10 from shared package uart_pkg.
REQ-031 SHALL place divider/tick generation in sub-module baud_tick_gen (inputs clk, reset, enable, clear; output tick).

Verification
REQ-032 Bench SHALL drive 0x55 (start 0, stop 1) at 9600 with controller model -> data=0x55, frame_error=0, one data_valid pulse.
REQ-033 Bench SHALL drive 0xA3 then 0x00 back-to-back -> two captures 0xA3, 0x00, bit_counter returns 0 between frames.
REQ-034 Bench SHALL drive 0xFF with stop bit 0 -> data=0xFF, frame_error=1.
REQ-035 Bench SHALL assert reset after 4 bits of a frame -> all outputs at reset values within same cycle; next frame 0x3C captured correctly.
REQ-036 Bench SHALL drop baud_enable for 1000 clk mid-frame -> bit_counter unchanged during gap, no sample taken.
REQ-037 Bench SHALL assert clear and tick in same cycle with phase==7 -> bit_counter=0, no shift.
